uart_boot_loader: RTL and testbench

UART-driven program loader placed upstream of the instruction SRAM in `soc_ahblite`. It receives a framed binary image on `uart_rx` and writes it word-by-word into the SRAM as an AHB-Lite master. It holds the core in reset until the image is verified, then acknowledges the host on `uart_tx`. In silicon and full-system runs it replaces back-door memory preloading.

---
 rtl/uart_boot_loader.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image over UART (8N1) and
// writes it word-by-word into instruction SRAM as an AHB-Lite master.
// The core is held in reset until the image checksum verifies; the host
// is answered with one ACK (8'h06) or NAK (8'h15) byte on uart_tx.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   uart_rx         asynchronous serial input, idle high
//   uart_tx         serial output for the ACK/NAK byte
//   haddr..hwdata   AHB-Lite master outputs (single word writes only)
//   hready, hresp   AHB-Lite slave response
//   core_rst        holds the CPU in reset until the load is verified
//   load_done       sticky, image written and checksum matched
//   load_err        sticky, framing/length/bus/checksum error
module uart_boot_loader #(
    parameter int unsigned CLK_DIV   = 868,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);
    localparam int unsigned CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bus_state_e;
    typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA,
                              S_CHK, S_SEND, S_DONE, S_ERROR} state_e;

    // RX registers
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          rx_ferr_q;
    logic          rx_s_c;

    // Main FSM registers
    state_e        state_q;
    bus_state_e    bus_q;
    logic [15:0]   len_q;
    logic [15:0]   word_idx_q;
    logic [1:0]    byte_cnt_q;
    logic [31:0]   asm_q;
    logic [7:0]    csum_q;
    logic [8:0]    tx_shift_q;
    logic [3:0]    tx_bits_q;
    logic [CW-1:0] tx_cnt_q;
    logic          send_ok_q;

    logic [15:0]   len_c;
    logic          word_fire_c;
    logic          bus_done_c;
    logic          bus_err_c;

    assign rx_s_c      = rx_sync_q[1];
    assign len_c       = {rx_byte_q, len_q[7:0]};
    assign word_fire_c = (state_q == S_DATA) && rx_valid_q && (byte_cnt_q == 2'd3)
                         && (bus_q == B_IDLE);
    assign bus_err_c   = (bus_q == B_DATA) && hresp;
    assign bus_done_c  = (bus_q == B_DATA) && !hresp && hready;
    assign hsize       = 3'b010;
    assign hburst      = 3'b000;

    // UART receiver: start bit re-checked at mid-bit to reject glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_s_c;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s_c) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s_c ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == DIV_END) begin
                        rx_cnt_q  <= '0;
                        rx_byte_q <= {rx_s_c, rx_byte_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == DIV_END) begin
                        rx_state_q <= RX_IDLE;
                        rx_valid_q <= rx_s_c;
                        rx_ferr_q  <= !rx_s_c;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // AHB-Lite write master: one outstanding single transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q  <= B_IDLE;
            haddr  <= '0;
            htrans <= HT_IDLE;
            hwrite <= 1'b0;
            hwdata <= '0;
        end else begin
            case (bus_q)
                B_IDLE: begin
                    if (word_fire_c) begin
                        bus_q  <= B_ADDR;
                        htrans <= HT_NONSEQ;
                        hwrite <= 1'b1;
                        haddr  <= BASE_ADDR + 32'({word_idx_q, 2'b00});
                        hwdata <= {rx_byte_q, asm_q[31:8]};
                    end
                end
                B_ADDR: begin
                    if (hready) begin
                        bus_q  <= B_DATA;
                        htrans <= HT_IDLE;
                        hwrite <= 1'b0;
                    end
                end
                B_DATA: begin
                    if (hresp || hready) bus_q <= B_IDLE;
                end
                default: bus_q <= B_IDLE;
            endcase
        end
    end

    // Frame parser, checksum, ACK/NAK transmitter and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SYNC;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            tx_shift_q <= '1;
            tx_bits_q  <= '0;
            tx_cnt_q   <= '0;
            send_ok_q  <= 1'b0;
            uart_tx    <= 1'b1;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state_q)
                S_SYNC, S_ERROR: begin
                    if (rx_valid_q && rx_byte_q == SYNC_BYTE) begin
                        state_q    <= S_LEN0;
                        load_err   <= 1'b0;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        csum_q     <= '0;
                    end
                end
                S_LEN0: begin
                    if (rx_valid_q) begin
                        len_q[7:0] <= rx_byte_q;
                        state_q    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (rx_valid_q) begin
                        len_q <= len_c;
                        if (32'(len_c) > MAX_WORDS) begin
                            // Oversized image: NAK now, then park in ERROR
                            state_q    <= S_SEND;
                            send_ok_q  <= 1'b0;
                            uart_tx    <= 1'b0;
                            tx_shift_q <= {1'b1, NAK_BYTE};
                            tx_bits_q  <= 4'd9;
                            tx_cnt_q   <= '0;
                        end else if (len_c == 16'd0) begin
                            state_q <= S_CHK;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus_err_c) begin
                        state_q  <= S_ERROR;
                        load_err <= 1'b1;
                    end else begin
                        if (bus_done_c) begin
                            word_idx_q <= word_idx_q + 16'd1;
                            if (word_idx_q + 16'd1 == len_q) state_q <= S_CHK;
                        end
                        if (rx_valid_q) begin
                            asm_q      <= {rx_byte_q, asm_q[31:8]};
                            csum_q     <= csum_q + rx_byte_q;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            // Word completed while the previous one is still on the bus
                            if (byte_cnt_q == 2'd3 && bus_q != B_IDLE) begin
                                state_q  <= S_ERROR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (rx_valid_q) begin
                        state_q    <= S_SEND;
                        send_ok_q  <= (rx_byte_q == csum_q);
                        uart_tx    <= 1'b0;
                        tx_shift_q <= {1'b1, (rx_byte_q == csum_q) ? ACK_BYTE : NAK_BYTE};
                        tx_bits_q  <= 4'd9;
                        tx_cnt_q   <= '0;
                    end
                end
                S_SEND: begin
                    // Start bit is already on the line; shift 8 data bits and stop bit
                    if (tx_cnt_q == DIV_END) begin
                        tx_cnt_q <= '0;
                        if (tx_bits_q == 4'd0) begin
                            if (send_ok_q) begin
                                state_q   <= S_DONE;
                                load_done <= 1'b1;
                                core_rst  <= 1'b0;
                            end else begin
                                state_q  <= S_ERROR;
                                load_err <= 1'b1;
                            end
                        end else begin
                            uart_tx    <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                            tx_bits_q  <= tx_bits_q - 4'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_DONE: ;
                default: state_q <= S_ERROR;
            endcase

            // Framing error aborts any load in progress
            if (rx_ferr_q && state_q != S_SEND && state_q != S_DONE) begin
                state_q  <= S_ERROR;
                load_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader (CLK_DIV = 16).
// Expected bus writes and expected ACK/NAK bytes are queued as frames are
// driven; an AHB slave model and a UART TX decoder pop and compare them.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam int unsigned DIV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        uart_tx;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_cnt   = 0;
    int wr_cnt   = 0;
    int n_wait   = 0;
    bit err_on_w1 = 1'b0;
    bit stall     = 1'b0;
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];

    uart_boot_loader #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_uart_tx",   32'(uart_tx),   32'd1);
        check("rst_htrans",    32'(htrans),    32'd0);
        check("rst_haddr",     haddr,          32'd0);
        check("rst_hwdata",    hwdata,         32'd0);
        check("rst_hwrite",    32'(hwrite),    32'd0);
        check("rst_core_rst",  32'(core_rst),  32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err",  32'(load_err),  32'd0);
        check("hsize",         32'(hsize),     32'd2);
        check("hburst",        32'(hburst),    32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_low);
        logic [9:0] f;
        f = {~stop_low, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    // Up to two words per frame; checksum is the byte sum of the payload
    task automatic send_frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input bit bad_csum, input int resp);
        logic [31:0] w;
        logic [7:0]  s;
        logic [7:0]  b;
        s = 8'h00;
        send_byte(8'hA5, 1'b0);
        send_byte(n[7:0], 1'b0);
        send_byte(n[15:8], 1'b0);
        for (int i = 0; i < int'(n); i++) begin
            w = (i == 0) ? w0 : w1;
            exp_wr.push_back({32'(i * 4), w});
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                s = s + b;
                send_byte(b, 1'b0);
            end
        end
        if (resp >= 0) exp_tx.push_back(8'(resp));
        send_byte(bad_csum ? 8'h00 : s, 1'b0);
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (tx_cnt < n && k < 20 * DIV) begin
            @(negedge clk);
            k++;
        end
        check("tx_count", 32'(tx_cnt), 32'(n));
        repeat (DIV + 4) @(negedge clk);
    endtask

    // AHB slave: optional wait states, optional error on word 1, optional stall
    initial begin : ahb_slave
        logic [31:0] a;
        logic [31:0] d;
        logic [63:0] e;
        hready = 1'b1;
        hresp  = 1'b0;
        forever begin
            @(negedge clk);
            hresp = 1'b0;
            if (htrans == 2'b10) begin
                a = haddr;
                check("hwrite", 32'(hwrite), 32'd1);
                for (int i = 0; i < n_wait; i++) begin
                    hready = 1'b0;
                    @(negedge clk);
                    check("addr_hold", haddr, a);
                    check("htrans_hold", 32'(htrans), 32'd2);
                end
                while (stall) begin
                    hready = 1'b0;
                    @(negedge clk);
                end
                hready = 1'b1;
                if (htrans == 2'b10) begin
                    @(negedge clk);
                    d = hwdata;
                    for (int i = 0; i < n_wait; i++) begin
                        hready = 1'b0;
                        @(negedge clk);
                        check("data_hold", hwdata, d);
                    end
                    hready = 1'b1;
                    hresp  = err_on_w1 && (a == 32'h4);
                    wr_cnt++;
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", a, e[63:32]);
                        check("wr_data", d, e[31:0]);
                    end
                end
            end
        end
    end

    // UART TX decoder: compares each received byte against the queue
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (DIV / 2) @(posedge clk);
            #1;
            check("tx_start", 32'(uart_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (DIV) @(posedge clk);
            #1;
            check("tx_stop", 32'(uart_tx), 32'd1);
            if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'd1);
            else                    check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            tx_cnt++;
        end
    end

    initial begin : main
        int w_before;
        uart_rx = 1'b1;
        rst     = 1'b1;
        do_reset();
        check_reset_vals();

        // Basic two-word load
        send_frame(16'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, 8'h06);
        wait_tx(1);
        check("basic_done", 32'(load_done), 32'd1);
        check("basic_core_rst", 32'(core_rst), 32'd0);
        check("basic_err", 32'(load_err), 32'd0);
        check("basic_writes", 32'(wr_cnt), 32'd2);
        // DONE ignores further bytes
        send_byte(8'hA5, 1'b0);
        repeat (12 * DIV) @(negedge clk);
        check("done_ignore_tx", 32'(tx_cnt), 32'd1);
        check("done_sticky", 32'(load_done), 32'd1);

        // Same image with three wait states per phase
        do_reset();
        n_wait = 3;
        send_frame(16'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, 8'h06);
        wait_tx(2);
        n_wait = 0;
        check("wait_done", 32'(load_done), 32'd1);
        check("wait_writes", 32'(wr_cnt), 32'd4);

        // Bad checksum, then a good frame recovers
        do_reset();
        send_frame(16'd2, 32'h12345678, 32'hDEADBEEF, 1'b1, 8'h15);
        wait_tx(3);
        check("badck_err", 32'(load_err), 32'd1);
        check("badck_core_rst", 32'(core_rst), 32'd1);
        check("badck_done", 32'(load_done), 32'd0);
        send_frame(16'd2, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 8'h06);
        wait_tx(4);
        check("recover_err", 32'(load_err), 32'd0);
        check("recover_done", 32'(load_done), 32'd1);

        // Oversized length, then N = 0
        do_reset();
        w_before = wr_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        exp_tx.push_back(8'h15);
        send_byte(8'h10, 1'b0);
        wait_tx(5);
        check("len_err", 32'(load_err), 32'd1);
        check("len_no_writes", 32'(wr_cnt), 32'(w_before));
        send_frame(16'd0, 32'h0, 32'h0, 1'b0, 8'h06);
        wait_tx(6);
        check("n0_done", 32'(load_done), 32'd1);
        check("n0_no_writes", 32'(wr_cnt), 32'(w_before));

        // False start inside a frame must not create a byte
        do_reset();
        send_byte(8'hA5, 1'b0);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_tx.push_back(8'h06);
        send_byte(8'h00, 1'b0);
        wait_tx(7);
        check("glitch_done", 32'(load_done), 32'd1);

        // Stop bit low
        do_reset();
        send_byte(8'hA5, 1'b1);
        check("frame_err", 32'(load_err), 32'd1);
        check("frame_core_rst", 32'(core_rst), 32'd1);

        // Bus error on word 1
        do_reset();
        err_on_w1 = 1'b1;
        send_frame(16'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, -1);
        err_on_w1 = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        check("hresp_err", 32'(load_err), 32'd1);
        check("hresp_htrans", 32'(htrans), 32'd0);
        check("hresp_core_rst", 32'(core_rst), 32'd1);
        check("hresp_no_tx", 32'(tx_cnt), 32'd7);

        // Reset while word 1 is stalled in its address phase
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_wr.push_back({32'h0, 32'hA1B2C3D4});
        send_byte(8'hD4, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hA1, 1'b0);
        stall = 1'b1;
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        check("stall_htrans", 32'(htrans), 32'd2);
        check("stall_haddr", haddr, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst   = 1'b0;
        stall = 1'b0;
        repeat (4) @(negedge clk);

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
